// File: rtl/dcnn_io_pkg.sv
// Shared definitions for the DCNN IO handlers.
// The run-word format lives here so the encoder and decoder agree on it.
package dcnn_io_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RUN_W  = 15;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SCAN,
        EMIT,
        FLUSH,
        FIN
    } chState_t;

    // Run word is {bit value, run length}; callers truncate to runW+1 bits.
    function automatic logic [31:0] packRun(
        input logic        b,
        input logic [30:0] run,
        input int          runW
    );
        return (32'(b) << runW) | {1'b0, run};
    endfunction

endpackage

// File: rtl/compress_handler_if.sv
// DMA read port plus run-word output bus of the compress handler.
// master is the handler side, slave the DMA/consumer side.
interface compress_handler_if #(
    parameter int ADDR_W = dcnn_io_pkg::DEF_ADDR_W,
    parameter int DATA_W = dcnn_io_pkg::DEF_DATA_W,
    parameter int RUN_W  = dcnn_io_pkg::DEF_RUN_W
) ();

    logic [ADDR_W-1:0] ramAddress;
    logic              ramReadSignal;
    logic [DATA_W-1:0] ramDataIn;
    logic              ramDoneRead;
    logic [RUN_W:0]    Dout;
    logic              doutValid;
    logic              doutReady;

    modport master (
        output ramAddress,
        output ramReadSignal,
        input  ramDataIn,
        input  ramDoneRead,
        output Dout,
        output doutValid,
        input  doutReady
    );

    modport slave (
        input  ramAddress,
        input  ramReadSignal,
        output ramDataIn,
        output ramDoneRead,
        input  Dout,
        input  doutValid,
        output doutReady
    );

endinterface

// File: rtl/rle_run_counter.sv
// Tracks the current bit value and run length of the scanned bitstream.
// Raises emitReq when the incoming bit ends or saturates the current run.
module rle_run_counter #(
    parameter int RUN_W = dcnn_io_pkg::DEF_RUN_W
) (
    input  logic           clk,
    input  logic           RST,
    input  logic           clr,
    input  logic           step,
    input  logic           bitIn,
    output logic           emitReq,
    output logic [RUN_W:0] emitWord,
    output logic [RUN_W:0] flushWord
);
    import dcnn_io_pkg::*;

    localparam int OW = RUN_W + 1;
    localparam logic [RUN_W-1:0] RUN_MAX = '1;

    logic             curBit;
    logic             curBitN;
    logic             first;
    logic             firstN;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] runN;

    assign emitReq = step && !first
                   && ((bitIn != curBit) || (run == RUN_MAX));

    always_comb begin
        curBitN = curBit;
        runN    = run;
        firstN  = first;
        if (clr) begin
            curBitN = 1'b0;
            runN    = '0;
            firstN  = 1'b1;
        end else if (step) begin
            if (first || emitReq) begin
                curBitN = bitIn;
                runN    = RUN_W'(1);
                firstN  = 1'b0;
            end else begin
                runN = run + RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            curBit <= 1'b0;
            run    <= '0;
            first  <= 1'b1;
        end else begin
            curBit <= curBitN;
            run    <= runN;
            first  <= firstN;
        end
    end

    // The run being closed, and the run as it stands after this cycle.
    assign emitWord  = OW'(packRun(curBit, 31'(run), RUN_W));
    assign flushWord = OW'(packRun(curBitN, 31'(runN), RUN_W));

endmodule

// File: rtl/compress_handler.sv
// Run-length encoder: fetches bytes over DMA, scans them LSB first,
// and emits one {bit,run} word per maximal run on a valid/ready bus.
module compress_handler #(
    parameter int ADDR_W = dcnn_io_pkg::DEF_ADDR_W,
    parameter int DATA_W = dcnn_io_pkg::DEF_DATA_W,
    parameter int RUN_W  = dcnn_io_pkg::DEF_RUN_W
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    input  logic [ADDR_W-1:0] numBytes,
    output logic              busy,
    output logic              done,
    compress_handler_if.master bus
);
    import dcnn_io_pkg::*;

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    chState_t          state;
    chState_t          stateNext;
    chState_t          resumeQ;
    logic [ADDR_W-1:0] baseQ;
    logic [ADDR_W-1:0] numQ;
    logic [ADDR_W-1:0] byteCnt;
    logic [ADDR_W-1:0] byteCntNext;
    logic [DATA_W-1:0] sr;
    logic [BW-1:0]     bitCnt;
    logic              clr;
    logic              step;
    logic              emitReq;
    logic              lastBit;
    logic              moreBytes;
    logic [RUN_W:0]    emitWord;
    logic [RUN_W:0]    flushWord;

    assign lastBit   = bitCnt == BW'(DATA_W - 1);
    assign moreBytes = (byteCnt + ADDR_W'(1)) != numQ;

    rle_run_counter #(
        .RUN_W(RUN_W)
    ) uRun (
        .clk      (clk),
        .RST      (RST),
        .clr      (clr),
        .step     (step),
        .bitIn    (sr[0]),
        .emitReq  (emitReq),
        .emitWord (emitWord),
        .flushWord(flushWord)
    );

    always_comb begin
        stateNext   = state;
        clr         = 1'b0;
        step        = 1'b0;
        byteCntNext = byteCnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    clr         = 1'b1;
                    byteCntNext = '0;
                    stateNext   = (numBytes == '0) ? FIN : FETCH;
                end
            end
            FETCH: begin
                if (bus.ramDoneRead) stateNext = SCAN;
            end
            SCAN: begin
                step = 1'b1;
                if (lastBit && moreBytes) byteCntNext = byteCnt + ADDR_W'(1);
                if (emitReq) stateNext = EMIT;
                else if (lastBit) stateNext = moreBytes ? FETCH : FLUSH;
            end
            EMIT: begin
                if (bus.doutValid && bus.doutReady) stateNext = resumeQ;
            end
            FLUSH: begin
                if (bus.doutValid && bus.doutReady) stateNext = FIN;
            end
            FIN: begin
                // FIN spans two cycles so done lands inside the busy window.
                if (done) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state             <= IDLE;
            resumeQ           <= SCAN;
            baseQ             <= '0;
            numQ              <= '0;
            byteCnt           <= '0;
            sr                <= '0;
            bitCnt            <= '0;
            bus.ramAddress    <= '0;
            bus.ramReadSignal <= 1'b0;
            bus.Dout          <= '0;
            bus.doutValid     <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= stateNext;
            byteCnt           <= byteCntNext;
            bus.ramReadSignal <= stateNext == FETCH;
            bus.doutValid     <= (stateNext == EMIT) || (stateNext == FLUSH);
            busy              <= stateNext != IDLE;
            done              <= (state == FIN) && !done;
            if (clr) begin
                baseQ <= baseAddr;
                numQ  <= numBytes;
            end
            if (stateNext == FETCH) begin
                bus.ramAddress <= (clr ? baseAddr : baseQ) + byteCntNext;
            end
            if (state == FETCH && bus.ramDoneRead) begin
                sr     <= bus.ramDataIn;
                bitCnt <= '0;
            end
            if (step) begin
                sr     <= sr >> 1;
                bitCnt <= bitCnt + BW'(1);
            end
            if (step && emitReq) begin
                bus.Dout <= emitWord;
                resumeQ  <= !lastBit ? SCAN : (moreBytes ? FETCH : FLUSH);
            end else if (stateNext == FLUSH && state != FLUSH) begin
                bus.Dout <= flushWord;
            end
        end
    end

endmodule

// File: doc/compress_handler.md
# compress_handler

Run-length encoder for the DCNN IO path: the transmit-side counterpart of the decompression datapath. On `start` it fetches `numBytes` bytes from RAM starting at `baseAddr` through the DMA read handshake. It treats the bytes as a bitstream, LSB first within each byte, and emits one run word per maximal run of equal bits on a valid/ready output. It sits between the DMA port and the external 16-bit output bus, alongside the file and decompress handlers.

## Interface
Parameters:
- `ADDR_W`, default 16: RAM address and byte-count width.
- `DATA_W`, default 8: RAM data width, i.e. bits scanned per fetched byte.
- `RUN_W`, default 15: run-length field width. Output word width is `RUN_W+1`.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `start` in 1: single-cycle pulse; accepted only in IDLE.
- `baseAddr` in ADDR_W: first RAM address; latched on start.
- `numBytes` in ADDR_W: byte count; latched on start.
- `ramAddress` out ADDR_W: read address to DMA.
- `ramReadSignal` out 1: read request to DMA.
- `ramDataIn` in DATA_W: read data from DMA.
- `ramDoneRead` in 1: DMA read-complete strobe; `ramDataIn` is valid in the same cycle.
- `Dout` out RUN_W+1: `{bit value, run length}`.
- `doutValid` out 1: `Dout` holds a word.
- `doutReady` in 1: consumer accepts.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at the end of a job.

## Operation
- FSM states: IDLE, FETCH, SCAN, EMIT, FLUSH, FIN.
- IDLE:
  - On `start`, latch `baseAddr` and `numBytes`, clear the byte counter, set the first-bit flag.
  - If `numBytes==0`, go to FIN. Otherwise go to FETCH.
- FETCH:
  - Drive `ramReadSignal=1` and `ramAddress=base+byteCnt`.
  - On `ramDoneRead`, capture `ramDataIn` into the shift register, clear the bit counter, go to SCAN.
- SCAN: consumes one bit per cycle (`sr[0]`), then shifts right.
  - First bit of the job: `curBit=bit`, `run=1`.
  - Bit equals `curBit` and `run` is below `2^RUN_W-1`: `run++`.
  - Bit differs, or `run` is saturated: load the output word `{curBit,run}`, set `curBit=bit`, `run=1`, go to EMIT (remaining byte bits are held).
  - After the last bit of a byte (bit index `DATA_W-1`):
    - more bytes remain: `byteCnt++`, go to FETCH;
    - no bytes remain: go to FLUSH.
- EMIT:
  - `doutValid=1` with `Dout` held stable until `doutReady`.
  - On the transfer cycle, return to the interrupted point. That is SCAN, or FETCH/FLUSH if the emit was triggered by the last bit of a byte.
- FLUSH: emit the final `{curBit,run}` with the same handshake as EMIT, then go to FIN.
- FIN: pulse `done` for one cycle, return to IDLE.
- Arithmetic and width rules:
  - Address is `base+byteCnt` modulo `2^ADDR_W`; wrap past 0xFFFF is permitted and silent.
  - `run` never exceeds `2^RUN_W-1`.
  - A saturated run emits a word, and the same bit continues with `run=1`.
  - Every emitted run length is ≥1.
- Boundary conditions:
  - `start` while `busy` is ignored; latched values are unchanged.
  - `ramDoneRead` outside FETCH is ignored.
  - `doutReady` without `doutValid` has no effect.
- Reset at any time returns to IDLE and discards the partial job; no word and no `done` are produced.

## Timing
- Reset values:
  - `ramAddress=0`, `ramReadSignal=0`;
  - `Dout=0`, `doutValid=0`;
  - `busy=0`, `done=0`.
- All outputs are registered.
- `start` to `ramReadSignal` high: 1 cycle.
- Read handshake:
  - `ramReadSignal` is held high until `ramDoneRead` is sampled high;
  - it is low in the following cycle.
- Scan rate: 1 bit/cycle when not stalled.
- Output handshake:
  - a word transfers on a cycle with `doutValid && doutReady`;
  - `doutValid` drops the next cycle unless a new word is loaded immediately;
  - no read request is issued while a word is pending.
- `numBytes==0`: `done` pulses 2 cycles after `start`, and `busy` is high for those 2 cycles.

## Structure
- Shared package `dcnn_io_pkg` holds:
  - FSM state encoding;
  - default `ADDR_W`, `DATA_W`, `RUN_W`;
  - a word-pack helper `{bit,run}`, shared with the decompress datapath so both ends agree on the format.
- One natural sub-module, `rle_run_counter`. It owns `curBit`, `run`, saturation, and emit-request generation. The FSM in `compress_handler` owns fetch, stall and handshakes.

## Test plan
- `numBytes=1`, byte 0xFF, `doutReady=1` → single word 0x8008, then `done`.
- `numBytes=1`, byte 0x0F → words 0x8004, 0x0004, in order.
- `numBytes=0` → no read, no word, `done` 2 cycles after `start`.
- `RUN_W=4`, `numBytes=2`, bytes 0xFF 0xFF → words 0x1F (`{1,15}`) and 0x11 (`{1,1}`).
- Backpressure, byte 0xF0 with `doutReady` low 5 cycles → `Dout=0x0004` stable throughout, no `ramReadSignal` during the stall, then 0x8004.
- Assert `RST` while in SCAN mid-job → all outputs at reset values; a following `start` runs a clean job.
